mix_cols_iter: RTL and testbench

- Iterative, handshaked AES MixColumns / InvMixColumns engine; successor to the combinational MixCols/InvMixCols pair.
- Mode is selectable per block, and the column-processing width is parametrised to trade area against latency.
- Sits between the ShiftRows / InvSubBytes stages of a future multi-cycle round datapath.
- Holds one 128-bit state in an internal register and transforms COLS_PER_CYCLE 32-bit columns per clock.

---
 rtl/mix_cols_iter.sv | 152 +++++++++++++++
 tb/tb_mix_cols_iter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_cols_iter.sv
// Iterative AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional MIXCOLS_BYPASS_EN adds in_bypass for pass-through (final-round) blocks.
module mix_cols_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
`ifdef MIXCOLS_BYPASS_EN
    input  logic         in_bypass,
`endif
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NGROUPS = 4 / COLS_PER_CYCLE;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_cols_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        fsm_q;
    state_t        fsm_d;
    logic [127:0]  state_q;
    logic [127:0]  state_run;
    logic [1:0]    grp_cnt;
    logic          mode_inv;
    logic          accept;
    logic          last_grp;
`ifdef MIXCOLS_BYPASS_EN
    logic          mode_bypass;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples by 2/4/8 are shared between the forward and inverse coefficient sets.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] r  [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                r[i] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            end else begin
                r[i] = x2[i]
                     ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ a[(i+2)%4]
                     ^ a[(i+3)%4];
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    assign accept   = in_valid && in_ready;
    assign last_grp = (grp_cnt == 2'(NGROUPS - 1));

    // Only the columns of the current group pass through the column units.
    always_comb begin
        int col_idx;
        col_idx   = 0;
        state_run = state_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx = int'(grp_cnt) * COLS_PER_CYCLE + k;
`ifdef MIXCOLS_BYPASS_EN
            if (!mode_bypass) begin
                state_run[127-32*col_idx -: 32] = mix_col(state_q[127-32*col_idx -: 32], mode_inv);
            end
`else
            state_run[127-32*col_idx -: 32] = mix_col(state_q[127-32*col_idx -: 32], mode_inv);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            grp_cnt     <= '0;
            mode_inv    <= 1'b0;
`ifdef MIXCOLS_BYPASS_EN
            mode_bypass <= 1'b0;
`endif
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                state_q     <= in_state;
                mode_inv    <= in_inv;
`ifdef MIXCOLS_BYPASS_EN
                mode_bypass <= in_bypass;
`endif
                grp_cnt     <= '0;
            end else if (fsm_q == RUN) begin
                state_q <= state_run;
                grp_cnt <= last_grp ? 2'd0 : grp_cnt + 2'd1;
            end
        end
    end

    // A DONE block retires and a new one is accepted on the same edge when both sides agree.
    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_grp) fsm_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) fsm_d = in_valid ? RUN : IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign out_state = state_q;

endmodule

// File: tb/tb_mix_cols_iter.sv
// Bench for mix_cols_iter: three instances (1/2/4 columns per cycle), table vectors,
// random blocks against a GF(2^8) matrix model, and handshake/reset sequences.
module tb_mix_cols_iter;

    logic         clk;
    logic         rst_n;
    logic         in_inv;
    logic         in_bypass;
    logic [127:0] in_state;
    logic         in_valid_a  [3];
    logic         out_ready_a [3];
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic         busy_a      [3];
    logic [127:0] out_state_a [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [127:0] st;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    mix_cols_iter #(.COLS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_inv(in_inv),
`ifdef MIXCOLS_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .in_state(in_state), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_state(out_state_a[0]), .busy(busy_a[0])
    );

    mix_cols_iter #(.COLS_PER_CYCLE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_inv(in_inv),
`ifdef MIXCOLS_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .in_state(in_state), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_state(out_state_a[1]), .busy(busy_a[1])
    );

    mix_cols_iter #(.COLS_PER_CYCLE(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_inv(in_inv),
`ifdef MIXCOLS_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .in_state(in_state), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .out_state(out_state_a[2]), .busy(busy_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-and-add multiply, reducing by the full 9-bit polynomial 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int t;
        p = 0;
        t = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t * 2;
            if (t > 255) t = t ^ 'h11b;
        end
        return 8'(p);
    endfunction

    // Circulant matrix product on each column; entry (r,j) uses coefficient (j-r) mod 4.
    function automatic logic [127:0] model(input logic [127:0] st, input logic inv, input logic byp);
        int           coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (byp) return st;
        if (inv) coef = '{14, 11, 13, 9};
        else     coef = '{2, 3, 1, 1};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(st[127-8*(4*c+j) -: 8], 8'(coef[(j - r + 4) % 4]));
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Sends one block to instance d, waits for the result, reports it and its latency, then retires it.
    task automatic applyStimulus(input int d, input logic [127:0] st, input logic inv, input logic byp,
                                 output logic [127:0] res, output int lat);
        int guard;
        @(negedge clk);
        in_state = st;
        in_inv   = inv;
        in_bypass = byp;
        in_valid_a[d] = 1'b1;
        guard = 0;
        while (!in_ready_a[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_a[d] = 1'b0;
        in_inv = ~inv;
        lat = 0;
        while (!out_valid_a[d] && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = out_state_a[d];
        out_ready_a[d] = 1'b1;
        @(negedge clk);
        out_ready_a[d] = 1'b0;
    endtask

    initial begin
        vec_t         vecs [6];
        logic [127:0] res;
        logic [127:0] held;
        logic [127:0] st;
        logic         inv;
        int           lat;
        int           exp_lat [3];

        exp_lat = '{4, 2, 1};
        vecs[0] = '{"fwd_vec",  128'hdb135345f20a225cd4d4d4d52d26314c, 1'b0, 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8};
        vecs[1] = '{"inv_vec",  128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8, 1'b1, 128'hdb135345f20a225cd4d4d4d52d26314c};
        vecs[2] = '{"fwd_01",   {16{8'h01}}, 1'b0, {16{8'h01}}};
        vecs[3] = '{"inv_01",   {16{8'h01}}, 1'b1, {16{8'h01}}};
        vecs[4] = '{"fwd_c6",   {16{8'hc6}}, 1'b0, {16{8'hc6}}};
        vecs[5] = '{"inv_c6",   {16{8'hc6}}, 1'b1, {16{8'hc6}}};

        rst_n = 1'b0;
        in_inv = 1'b0;
        in_bypass = 1'b0;
        in_state = '0;
        for (int d = 0; d < 3; d++) begin
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b0;
        end
        #12;
        checkOutput("reset_in_ready",  128'(in_ready_a[0]),  128'd1);
        checkOutput("reset_out_valid", 128'(out_valid_a[0]), 128'd0);
        checkOutput("reset_busy",      128'(busy_a[0]),      128'd0);
        checkOutput("reset_out_state", out_state_a[0],       128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, vecs[i].st, vecs[i].inv, 1'b0, res, lat);
            checkOutput(vecs[i].name, res, vecs[i].exp);
            checkOutput({vecs[i].name, "_lat"}, 128'(lat), 128'd4);
        end

        $display("[TB] parameter sweep");
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d, {4{32'h2d26314c}}, 1'b0, 1'b0, res, lat);
            checkOutput($sformatf("sweep%0d", d), res, {4{32'h4d7ebdf8}});
            checkOutput($sformatf("sweep%0d_lat", d), 128'(lat), 128'(exp_lat[d]));
        end

        $display("[TB] random blocks");
        for (int n = 0; n < 12; n++) begin
            for (int d = 0; d < 3; d++) begin
                st  = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                applyStimulus(d, st, inv, 1'b0, res, lat);
                checkOutput($sformatf("rand%0d_dut%0d", n, d), res, model(st, inv, 1'b0));
            end
        end

        $display("[TB] backpressure");
        @(negedge clk);
        in_state = vecs[0].st;
        in_inv = 1'b0;
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        lat = 0;
        while (!out_valid_a[0] && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        held = out_state_a[0];
        checkOutput("bp_result", held, vecs[0].exp);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
            checkOutput("bp_out_state", out_state_a[0], held);
            checkOutput("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
        end
        in_state = {4{32'hf20a225c}};
        in_inv = 1'b0;
        in_valid_a[0] = 1'b1;
        out_ready_a[0] = 1'b1;
        #1;
        checkOutput("b2b_in_ready", 128'(in_ready_a[0]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        out_ready_a[0] = 1'b0;
        checkOutput("b2b_out_valid_low", 128'(out_valid_a[0]), 128'd0);
        checkOutput("b2b_busy", 128'(busy_a[0]), 128'd1);
        lat = 0;
        while (!out_valid_a[0] && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("b2b_lat", 128'(lat), 128'd4);
        checkOutput("b2b_result", out_state_a[0], {4{32'h9fdc589d}});
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;

        $display("[TB] reset during RUN");
        @(negedge clk);
        in_state = vecs[0].st;
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 128'(out_valid_a[0]), 128'd0);
        checkOutput("rst_busy",      128'(busy_a[0]),      128'd0);
        checkOutput("rst_in_ready",  128'(in_ready_a[0]),  128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_stale_valid", 128'(out_valid_a[0]), 128'd0);
        applyStimulus(0, {16{8'h01}}, 1'b0, 1'b0, res, lat);
        checkOutput("rst_next_block", res, {16{8'h01}});
        checkOutput("rst_next_lat", 128'(lat), 128'd4);

`ifdef MIXCOLS_BYPASS_EN
        $display("[TB] bypass");
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d, {4{32'hf20a225c}}, 1'b1, 1'b1, res, lat);
            checkOutput($sformatf("bypass%0d", d), res, {4{32'hf20a225c}});
            checkOutput($sformatf("bypass%0d_lat", d), 128'(lat), 128'(exp_lat[d]));
            applyStimulus(d, {4{32'hf20a225c}}, 1'b0, 1'b0, res, lat);
            checkOutput($sformatf("nobypass%0d", d), res, {4{32'h9fdc589d}});
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
